// File: rtl/sarray_mem_resp_pkg.sv
// Shared gnpu defines for the line-array responder: bus widths that
// initiators and this responder must agree on, plus arbiter constants.
package sarray_mem_resp_pkg;

    // Bus geometry shared with every gnpu initiator.
    localparam int GNPU_ADDR_WIDTH  = 64;
    localparam int GNPU_LOAD_WIDTH  = 256;
    localparam int GNPU_STORE_WIDTH = 256;
    localparam int GNPU_LINE_SHIFT  = 8;

    // After this many back-to-back write grants that each blocked an
    // eligible read, the read wins one cycle.
    localparam int STARVE_LIMIT = 4;
    localparam int STARVE_CNT_W = 3;

    // The return path holds at most two lines (buffered + in flight).
    localparam int RET_FIFO_DEPTH = 2;

    // Per-cycle decision of the single-port array arbiter.
    typedef enum logic [1:0] {
        GRANT_NONE  = 2'd0,
        GRANT_READ  = 2'd1,
        GRANT_WRITE = 2'd2
    } grant_e;

endpackage : sarray_mem_resp_pkg

// File: rtl/sarray_mem_resp_sync_fifo.sv
// Small synchronous FIFO with full/empty flags and same-edge push/pop.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO or a pop from an empty one is dropped.
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = entries[rd_ptr];

    // Pointer and occupancy bookkeeping, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) entries[wr_ptr] <= push_data;
    end

endmodule : sync_fifo

// File: rtl/sarray_mem_resp.sv
// Line-array memory responder: AR requests queue up, share one
// single-port synchronous array with full-line writes, and return data
// through a two-entry FIFO.
//
// Handshake semantics (all channels): a transfer happens on the rising
// edge where valid and ready are both high. ar_ready_o never looks at
// ar_valid_i; aw_ready_o is the arbiter's write grant and so follows
// aw_valid_i combinationally; r_valid_o/r_data_o stay put until r_ready_i.
module sarray_mem_resp
    import sarray_mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH  = GNPU_ADDR_WIDTH,
    parameter int LOAD_WIDTH  = GNPU_LOAD_WIDTH,
    parameter int STORE_WIDTH = GNPU_STORE_WIDTH, // must equal LOAD_WIDTH
    parameter int LINE_SHIFT  = GNPU_LINE_SHIFT,
    parameter int MEM_DEPTH   = 256,
    parameter int AR_Q_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ar_valid_i,
    output logic                   ar_ready_o,
    input  logic [ADDR_WIDTH-1:0]  ar_addr_i,
    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic [LOAD_WIDTH-1:0]  r_data_o,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [ADDR_WIDTH-1:0]  aw_addr_i,
    input  logic [STORE_WIDTH-1:0] aw_data_i,
    output logic                   misalign_err_o
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [IDX_W-1:0]        ar_idx;
    logic [IDX_W-1:0]        aw_idx;
    logic [IDX_W-1:0]        arq_head_idx;
    logic [IDX_W-1:0]        mem_idx;
    logic                    arq_push;
    logic                    arq_full;
    logic                    arq_empty;
    logic                    ret_pop;
    logic                    ret_full;
    logic                    ret_empty;
    logic [1:0]              ret_occ;
    logic [1:0]              ret_occ_eff;
    logic                    credit;
    logic                    rd_elig;
    logic                    wr_elig;
    grant_e                  grant;
    logic                    rd_gnt;
    logic                    wr_gnt;
    logic                    rd_inflight;
    logic [LOAD_WIDTH-1:0]   rd_line;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic                    unused_addr_hi;

    logic [LOAD_WIDTH-1:0]   line_mem [MEM_DEPTH];

    // Higher address bits are ignored: line indexes wrap modulo MEM_DEPTH.
    assign ar_idx         = ar_addr_i[LINE_SHIFT +: IDX_W];
    assign aw_idx         = aw_addr_i[LINE_SHIFT +: IDX_W];
    assign unused_addr_hi = ^{ar_addr_i[ADDR_WIDTH-1:LINE_SHIFT+IDX_W],
                              aw_addr_i[ADDR_WIDTH-1:LINE_SHIFT+IDX_W]};

    // ---------------- AR queue ----------------
    assign ar_ready_o = !arq_full;
    assign arq_push   = ar_valid_i && ar_ready_o;

    sync_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (AR_Q_DEPTH)
    ) u_ar_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (arq_push),
        .push_data (ar_idx),
        .pop       (rd_gnt),
        .head_data (arq_head_idx),
        .full      (arq_full),
        .empty     (arq_empty)
    );

    // ---------------- return path ----------------
    assign r_valid_o = !ret_empty;
    assign ret_pop   = r_valid_o && r_ready_i;

    sync_fifo #(
        .WIDTH (LOAD_WIDTH),
        .DEPTH (RET_FIFO_DEPTH)
    ) u_ret_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_inflight),
        .push_data (rd_line),
        .pop       (ret_pop),
        .head_data (r_data_o),
        .full      (ret_full),
        .empty     (ret_empty)
    );

    // Occupancy counts the entry leaving on this edge as already gone,
    // which keeps the read pipe at one line per cycle while draining and
    // still never lets buffered plus in-flight lines exceed two.
    assign ret_occ     = ret_full ? 2'd2 : (ret_empty ? 2'd0 : 2'd1);
    assign ret_occ_eff = ret_occ - {1'b0, ret_pop};
    assign credit      = (ret_occ_eff + {1'b0, rd_inflight}) < 2'd2;

    // ---------------- arbiter ----------------
    assign rd_elig = !arq_empty && credit;
    assign wr_elig = aw_valid_i;

    // Writes win contention until STARVE_LIMIT of them in a row have
    // blocked an eligible read; then the read gets this cycle.
    always_comb begin
        grant = GRANT_NONE;
        if (wr_elig && rd_elig) begin
            grant = (starve_cnt == STARVE_CNT_W'(STARVE_LIMIT)) ? GRANT_READ : GRANT_WRITE;
        end else if (wr_elig) begin
            grant = GRANT_WRITE;
        end else if (rd_elig) begin
            grant = GRANT_READ;
        end
    end

    assign rd_gnt     = (grant == GRANT_READ);
    assign wr_gnt     = (grant == GRANT_WRITE);
    assign aw_ready_o = wr_gnt;

    // Count consecutive contended write grants; any other cycle restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (wr_gnt && rd_elig) begin
            starve_cnt <= starve_cnt + STARVE_CNT_W'(1);
        end else begin
            starve_cnt <= '0;
        end
    end

    // ---------------- single-port line array ----------------
    assign mem_idx = wr_gnt ? aw_idx : arq_head_idx;

    // One access per edge: either write the line or register its contents.
    always_ff @(posedge clk) begin
        if (wr_gnt) line_mem[mem_idx] <= aw_data_i;
        if (rd_gnt) rd_line <= line_mem[mem_idx];
    end

    // The registered read data is pushed into the return FIFO next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= rd_gnt;
        end
    end

    // Sticky misalignment flag over every accepted address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err_o <= 1'b0;
        end else if ((arq_push && (|ar_addr_i[LINE_SHIFT-1:0])) ||
                     (wr_gnt && (|aw_addr_i[LINE_SHIFT-1:0]))) begin
            misalign_err_o <= 1'b1;
        end
    end

endmodule : sarray_mem_resp

// File: tb/tb_sarray_mem_resp.sv
// Directed bench for sarray_mem_resp with default parameters.
module tb_sarray_mem_resp;

  localparam int AW = 64;
  localparam int LW = 256;

  logic          clk;
  logic          rst_n;
  logic          ar_valid_i;
  logic          ar_ready_o;
  logic [AW-1:0] ar_addr_i;
  logic          r_valid_o;
  logic          r_ready_i;
  logic [LW-1:0] r_data_o;
  logic          aw_valid_i;
  logic          aw_ready_o;
  logic [AW-1:0] aw_addr_i;
  logic [LW-1:0] aw_data_i;
  logic          misalign_err_o;

  int total = 0;
  int bad = 0;
  logic [LW-1:0] exp_q[$];

  sarray_mem_resp dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ar_valid_i     (ar_valid_i),
    .ar_ready_o     (ar_ready_o),
    .ar_addr_i      (ar_addr_i),
    .r_valid_o      (r_valid_o),
    .r_ready_i      (r_ready_i),
    .r_data_o       (r_data_o),
    .aw_valid_i     (aw_valid_i),
    .aw_ready_o     (aw_ready_o),
    .aw_addr_i      (aw_addr_i),
    .aw_data_i      (aw_data_i),
    .misalign_err_o (misalign_err_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  task automatic aw_write(input logic [AW-1:0] addr, input logic [LW-1:0] data);
    int n;
    n = 0;
    @(negedge clk);
    aw_valid_i = 1'b1;
    aw_addr_i = addr;
    aw_data_i = data;
    #1;
    while (!aw_ready_o && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!aw_ready_o) begin
      total++;
      bad++;
      $display("FAIL aw_timeout: addr=%0h got no aw_ready in 50 cycles, want grant", addr);
    end
    @(posedge clk);
    #1;
    aw_valid_i = 1'b0;
  endtask

  task automatic read_line(input logic [AW-1:0] addr, output logic [LW-1:0] data, output bit ok);
    int n;
    ok = 1'b0;
    data = '0;
    r_ready_i = 1'b1;
    @(negedge clk);
    ar_valid_i = 1'b1;
    ar_addr_i = addr;
    #1;
    n = 0;
    while (!ar_ready_o && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    ar_valid_i = 1'b0;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      #1;
      if (r_valid_o) begin
        data = r_data_o;
        ok = 1'b1;
        break;
      end
      n++;
    end
    @(posedge clk);
    #1;
    r_ready_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    ar_valid_i = 1'b0;
    ar_addr_i = '0;
    r_ready_i = 1'b0;
    aw_valid_i = 1'b0;
    aw_addr_i = '0;
    aw_data_i = '0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (ar_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ar_ready: got %b want 1", ar_ready_o); end
    total++;
    if (r_valid_o !== 1'b0) begin bad++; $display("FAIL rst_r_valid: got %b want 0", r_valid_o); end
    total++;
    if (aw_ready_o !== 1'b0) begin bad++; $display("FAIL rst_aw_ready: got %b want 0", aw_ready_o); end
    total++;
    if (misalign_err_o !== 1'b0) begin bad++; $display("FAIL rst_misalign: got %b want 0", misalign_err_o); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (ar_ready_o !== 1'b1 || r_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL post_rst: ar_ready=%b r_valid=%b want 1/0", ar_ready_o, r_valid_o);
    end
  endtask

  task automatic test_write_read;
    logic [LW-1:0] a;
    a = {8{32'hA5A5_1234}};
    aw_write(64'h100, a);
    r_ready_i = 1'b1;
    @(negedge clk);
    ar_valid_i = 1'b1;
    ar_addr_i = 64'h100;
    #1;
    total++;
    if (ar_ready_o !== 1'b1) begin bad++; $display("FAIL wr_rd_ar_ready: got %b want 1", ar_ready_o); end
    @(posedge clk);   // AR handshake edge N
    #1;
    ar_valid_i = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (r_valid_o !== 1'b0) begin bad++; $display("FAIL lat_n0: r_valid got %b want 0", r_valid_o); end
    @(negedge clk);
    #1;
    total++;
    if (r_valid_o !== 1'b0) begin bad++; $display("FAIL lat_n1: r_valid got %b want 0", r_valid_o); end
    @(negedge clk);
    #1;
    total++;
    if (r_valid_o !== 1'b1) begin bad++; $display("FAIL lat_n2: r_valid got %b want 1", r_valid_o); end
    total++;
    if (r_data_o !== a) begin bad++; $display("FAIL wr_rd_data: got %h want %h", r_data_o, a); end
    @(posedge clk);
    #1;
    r_ready_i = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (r_valid_o !== 1'b0) begin bad++; $display("FAIL wr_rd_drain: r_valid got %b want 0", r_valid_o); end
  endtask

  task automatic test_burst;
    int acc;
    int got;
    int first;
    int last;
    logic [LW-1:0] e;
    for (int i = 0; i < 64; i++) aw_write(64'(i) << 8, LW'(i));
    acc = 0;
    got = 0;
    first = -1;
    last = -1;
    r_ready_i = 1'b1;
    fork
      begin : drv
        int guard;
        guard = 0;
        @(negedge clk);
        ar_valid_i = 1'b1;
        ar_addr_i = '0;
        while (acc < 64 && guard < 300) begin
          #1;
          if (ar_ready_o) begin
            exp_q.push_back(LW'(acc));
            acc++;
          end
          @(negedge clk);
          guard++;
          if (acc < 64) ar_addr_i = 64'(acc) << 8;
          else ar_valid_i = 1'b0;
        end
        ar_valid_i = 1'b0;
      end
      begin : mon
        for (int c = 0; c < 300 && got < 64; c++) begin
          @(negedge clk);
          #2;
          if (r_valid_o) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL burst_extra: got %h with nothing expected", r_data_o);
            end else begin
              e = exp_q.pop_front();
              if (r_data_o !== e) begin bad++; $display("FAIL burst_data: got %h want %h", r_data_o, e); end
            end
            if (first < 0) first = c;
            last = c;
            got++;
          end
        end
      end
    join
    @(posedge clk);
    #1;
    r_ready_i = 1'b0;
    total++;
    if (got !== 64) begin bad++; $display("FAIL burst_count: got %0d want 64", got); end
    total++;
    if (last - first !== 63) begin bad++; $display("FAIL burst_rate: span %0d want 63", last - first); end
    exp_q.delete();
  endtask

  task automatic test_backpressure;
    int acc;
    int got;
    logic [LW-1:0] e;
    acc = 0;
    got = 0;
    r_ready_i = 1'b0;
    fork
      begin : drv
        int guard;
        guard = 0;
        @(negedge clk);
        ar_valid_i = 1'b1;
        ar_addr_i = 64'(10) << 8;
        while (acc < 10 && guard < 300) begin
          #1;
          if (ar_ready_o) begin
            exp_q.push_back(LW'(10 + acc));
            acc++;
          end
          @(negedge clk);
          guard++;
          if (acc < 10) ar_addr_i = 64'(10 + acc) << 8;
          else ar_valid_i = 1'b0;
        end
        ar_valid_i = 1'b0;
      end
      begin : stall_and_drain
        for (int k = 0; k < 11; k++) begin
          @(negedge clk);
          #2;
          if (k >= 4) begin
            total++;
            if (r_valid_o !== 1'b1 || r_data_o !== LW'(10)) begin
              bad++;
              $display("FAIL bp_hold: r_valid=%b data=%h want 1/%h", r_valid_o, r_data_o, LW'(10));
            end
          end
        end
        total++;
        if (acc !== 6) begin bad++; $display("FAIL bp_accepted: got %0d want 6", acc); end
        total++;
        if (ar_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ar_ready: got %b want 0", ar_ready_o); end
        r_ready_i = 1'b1;
        for (int c = 0; c < 100 && got < 10; c++) begin
          if (r_valid_o) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL bp_extra: got %h with nothing expected", r_data_o);
            end else begin
              e = exp_q.pop_front();
              if (r_data_o !== e) begin bad++; $display("FAIL bp_data: got %h want %h", r_data_o, e); end
            end
            got++;
          end
          if (got < 10) begin
            @(negedge clk);
            #2;
          end
        end
      end
    join
    @(posedge clk);
    #1;
    r_ready_i = 1'b0;
    total++;
    if (got !== 10) begin bad++; $display("FAIL bp_count: got %0d want 10", got); end
    exp_q.delete();
  endtask

  task automatic test_contention;
    int j;
    int lows;
    int low_at;
    logic [LW-1:0] d;
    bit ok;
    r_ready_i = 1'b0;
    @(negedge clk);
    ar_valid_i = 1'b1;
    ar_addr_i = 64'h300;
    #1;
    total++;
    if (ar_ready_o !== 1'b1) begin bad++; $display("FAIL cont_ar_ready: got %b want 1", ar_ready_o); end
    @(posedge clk);
    #1;
    ar_valid_i = 1'b0;
    j = 0;
    lows = 0;
    low_at = -1;
    @(negedge clk);
    aw_valid_i = 1'b1;
    for (int c = 0; c < 40 && j < 8; c++) begin
      aw_addr_i = 64'(32 + j) << 8;
      aw_data_i = LW'(32'h100 + j);
      #1;
      if (aw_ready_o) j++;
      else begin
        lows++;
        if (low_at < 0) low_at = j;
      end
      @(negedge clk);
    end
    aw_valid_i = 1'b0;
    total++;
    if (j !== 8) begin bad++; $display("FAIL cont_writes: got %0d want 8", j); end
    total++;
    if (lows !== 1) begin bad++; $display("FAIL cont_low_cycles: got %0d want 1", lows); end
    total++;
    if (low_at !== 4) begin bad++; $display("FAIL cont_low_after: got %0d writes want 4", low_at); end
    #1;
    total++;
    if (r_valid_o !== 1'b1 || r_data_o !== LW'(3)) begin
      bad++;
      $display("FAIL cont_read: r_valid=%b data=%h want 1/%h", r_valid_o, r_data_o, LW'(3));
    end
    r_ready_i = 1'b1;
    @(posedge clk);
    #1;
    r_ready_i = 1'b0;
    read_line(64'h2000, d, ok);
    total++;
    if (!ok || d !== LW'(32'h100)) begin bad++; $display("FAIL cont_line32: got %h want %h", d, LW'(32'h100)); end
    read_line(64'h2700, d, ok);
    total++;
    if (!ok || d !== LW'(32'h107)) begin bad++; $display("FAIL cont_line39: got %h want %h", d, LW'(32'h107)); end
  endtask

  task automatic test_wrap_err;
    logic [LW-1:0] b;
    logic [LW-1:0] d;
    bit ok;
    b = {4{64'hBEEF_0000_CAFE_0001}};
    total++;
    if (misalign_err_o !== 1'b0) begin bad++; $display("FAIL err_pre: got %b want 0", misalign_err_o); end
    aw_write(64'h10100, b);
    read_line(64'h100, d, ok);
    total++;
    if (!ok || d !== b) begin bad++; $display("FAIL wrap_data: got %h want %h", d, b); end
    total++;
    if (misalign_err_o !== 1'b0) begin bad++; $display("FAIL err_aligned: got %b want 0", misalign_err_o); end
    read_line(64'h104, d, ok);
    total++;
    if (!ok || d !== b) begin bad++; $display("FAIL misalign_data: got %h want %h", d, b); end
    total++;
    if (misalign_err_o !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", misalign_err_o); end
    repeat (5) @(negedge clk);
    read_line(64'h200, d, ok);
    total++;
    if (misalign_err_o !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", misalign_err_o); end
  endtask

  task automatic test_reset_midop;
    int acc;
    int spurious;
    acc = 0;
    spurious = 0;
    r_ready_i = 1'b1;
    @(negedge clk);
    aw_valid_i = 1'b1;
    aw_addr_i = 64'h3200;
    aw_data_i = LW'(32'h5555);
    ar_valid_i = 1'b1;
    ar_addr_i = '0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (ar_ready_o && ar_valid_i) acc++;
      @(negedge clk);
      if (acc >= 4) ar_valid_i = 1'b0;
      else ar_addr_i = 64'(acc) << 8;
    end
    #2;
    total++;
    if (r_valid_o !== 1'b0) begin bad++; $display("FAIL midop_pre: r_valid got %b want 0", r_valid_o); end
    rst_n = 1'b0;
    aw_valid_i = 1'b0;
    ar_valid_i = 1'b0;
    #1;
    total++;
    if (ar_ready_o !== 1'b1 || r_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL midop_in_rst: ar_ready=%b r_valid=%b want 1/0", ar_ready_o, r_valid_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (ar_ready_o !== 1'b1 || r_valid_o !== 1'b0 || aw_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL midop_post: ar_ready=%b r_valid=%b aw_ready=%b want 1/0/0", ar_ready_o, r_valid_o, aw_ready_o);
    end
    total++;
    if (misalign_err_o !== 1'b0) begin bad++; $display("FAIL midop_err_clr: got %b want 0", misalign_err_o); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (r_valid_o) spurious++;
    end
    total++;
    if (spurious !== 0) begin bad++; $display("FAIL midop_spurious: got %0d responses want 0", spurious); end
    r_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_burst();
    test_backpressure();
    test_contention();
    test_wrap_err();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sarray_mem_resp

// File: doc/sarray_mem_resp.md
SARRAY_MEM_RESP -- requirements
Module: sarray_mem_resp

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, byte-address width of the AR and AW channels.
REQ-002 Parameter LOAD_WIDTH, default 256, width of the R data in bits.
REQ-003 Parameter STORE_WIDTH, default 256, width of the AW data in bits; it SHALL equal LOAD_WIDTH.
REQ-004 Parameter LINE_SHIFT, default 8, log2 of the line stride in bytes.
REQ-005 Parameter MEM_DEPTH, default 256, number of lines; it SHALL be a power of 2.
REQ-006 Parameter AR_Q_DEPTH, default 4, depth of the read-request queue; it SHALL be a power of 2.
REQ-007 clk  input  1  clock; all logic is rising-edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 ar_valid_i  input  1  read request valid.
REQ-010 ar_ready_o  output  1  read request accepted.
REQ-011 ar_addr_i  input  ADDR_WIDTH  read byte address.
REQ-012 r_valid_o  output  1  read data valid.
REQ-013 r_ready_i  input  1  read data consumed.
REQ-014 r_data_o  output  LOAD_WIDTH  read data.
REQ-015 aw_valid_i  input  1  write valid; address and data arrive together.
REQ-016 aw_ready_o  output  1  write accepted.
REQ-017 aw_addr_i  input  ADDR_WIDTH  write byte address.
REQ-018 aw_data_i  input  STORE_WIDTH  write data, one full line.
REQ-019 misalign_err_o  output  1  sticky flag, set when any accepted address has nonzero bits [LINE_SHIFT-1:0].

Function
REQ-020 A handshake on any channel SHALL occur when valid and ready are both high at a rising edge.
REQ-021 The line index SHALL be addr[LINE_SHIFT+log2(MEM_DEPTH)-1 : LINE_SHIFT]; higher address bits are ignored, so indexes wrap modulo MEM_DEPTH.
REQ-022 ar_ready_o SHALL equal "AR queue not full"; it SHALL be independent of ar_valid_i.
REQ-023 Accepted AR addresses SHALL be served strictly in acceptance order.
REQ-024 Storage SHALL be a single-port, synchronous-read line array that performs at most one access per cycle, either one read or one write.
REQ-025 Per-cycle arbiter rule: a read is eligible when the AR queue is non-empty and the return credit is available; a write is eligible when aw_valid_i is high.
REQ-026 When only one access is eligible, it SHALL be granted.
REQ-027 When both are eligible, the write SHALL be granted, unless 4 consecutive writes have already been granted while a read was eligible; in that case the read SHALL be granted and the counter cleared.
REQ-028 aw_ready_o SHALL be high exactly when the write is granted in that cycle; aw_ready_o depends combinationally on aw_valid_i.
REQ-029 The return path SHALL be a 2-entry FIFO.
REQ-030 Return credit is available when FIFO occupancy plus reads in flight is less than 2.
REQ-031 r_valid_o SHALL equal "return FIFO not empty", and r_data_o SHALL be the FIFO head.
REQ-032 r_valid_o and r_data_o SHALL hold stable while r_valid_o is high and r_ready_i is low.
REQ-033 Minimum read latency: with the queue empty, no write pending, and r_ready_i high, an AR handshake at edge N SHALL yield r_valid_o high after edge N+2.
REQ-034 Full AR throughput SHALL be one read response per cycle when r_ready_i is held high and no writes are pending.
REQ-035 A write granted at edge W SHALL be visible to any read granted at edge W+1 or later.
REQ-036 An AR accepted before a write to the same line, but read after that write is granted, SHALL return the new data; no ordering between the AR and AW channels is promised.
REQ-037 An AR handshake on the same edge that the queue head is popped SHALL be allowed only when the queue was not full before that edge.
REQ-038 The return FIFO SHALL support a simultaneous push and pop on the same edge.
REQ-039 misalign_err_o SHALL only be cleared by reset; misaligned requests are still served using the truncated index.
REQ-040 Storage contents SHALL NOT be initialised; reading an unwritten line returns undefined data, and the bench SHALL NOT check it.

Reset
REQ-041 On reset, all state SHALL clear asynchronously: AR queue pointers, return FIFO, in-flight flag, starvation counter, and misalign_err_o.
REQ-042 During and immediately after reset: ar_ready_o=1, r_valid_o=0, and aw_ready_o=0 unless aw_valid_i is high.
REQ-043 Reset asserted mid-operation SHALL discard all queued and in-flight reads; no stale response SHALL appear after deassertion.
REQ-044 Storage array contents are not reset.

Structure
REQ-045 ADDR_WIDTH, LOAD_WIDTH, STORE_WIDTH, and LINE_SHIFT SHALL come from the shared gnpu defines package, so that initiators and this responder agree on them.
REQ-046 A single sub-module sync_fifo (parameterised width and depth, with full, empty, and simultaneous push/pop support) SHALL be used for both the AR queue and the return FIFO.
REQ-047 The line array SHALL be inferred inline as a single-port memory.

Verification
REQ-048 Write then read: AW addr 0x100, data A, then AR 0x100 -> r_data_o=A, with r_valid_o high 2 cycles after the AR handshake.
REQ-049 Burst of 64 ARs at 0x0, 0x100, ..., 0x3F00 (lines preloaded with their index), r_ready_i=1 -> 64 responses in order, one per cycle, data = index.
REQ-050 Backpressure: r_ready_i=0 for 10 cycles during a burst -> ar_ready_o drops after 4 queued requests plus 2 returns; data is held stable; nothing is lost after release.
REQ-051 Contention: aw_valid_i held high with 8 writes while 1 AR is queued -> the read is granted after the 4th write; aw_ready_o is low for that one cycle.
REQ-052 Wrap and error: AW to 0x10100 then AR to 0x100 -> the same data is returned; AR at 0x104 -> misalign_err_o=1 and it stays set.
REQ-053 Reset asserted with 3 reads queued and 1 in flight -> r_valid_o=0 after deassertion, ar_ready_o=1, and no spurious response within 10 cycles.
